// File: rtl/bram_pkg.sv
// Shared types and address-check helpers for the block RAM model.
// Holds the sweep FSM encoding and the 32-bit window/alignment test.
package bram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;

  // An access is rejected when it is below the window, past the last word,
  // or not on a word boundary. The offset wraps modulo 2^32 by construction.
  function automatic logic addr_bad(input addr_t addr, input addr_t base,
                                    input int unsigned lane_bits, input addr_t depth);
    addr_t off;
    addr_t idx;
    addr_t mask;
    off  = addr - base;
    idx  = off >> lane_bits;
    mask = (addr_t'(1) << lane_bits) - addr_t'(1);
    return (addr < base) || (idx >= depth) || ((addr & mask) != '0);
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read return pipeline: STAGES-deep shift register of {valid, err, data}.
// Latency STAGES cycles; no backpressure, one beat accepted per cycle.
// Data stages load only on a valid beat, so the last stage holds the last read.
module bram_rd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  output logic              out_err,
  output logic [DATA_W-1:0] out_dat
);

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] err_q;
  logic [DATA_W-1:0] dat_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        dat_q[i] <= '1;
      end
    end else begin
      vld_q[0] <= in_vld;
      err_q[0] <= in_err;
      if (in_vld) begin
        dat_q[0] <= in_dat;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_vld = vld_q[STAGES-1];
  assign out_err = err_q[STAGES-1];
  assign out_dat = dat_q[STAGES-1];

endmodule

// File: rtl/bram_model.sv
// Byte-addressed word RAM with self-initialising sweep and error reporting.
// Read latency RD_LAT cycles; write error strobe one cycle after the request.
// No backpressure: one request per cycle, requests ignored while busy.
module bram_model
  import bram_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [31:0]       BASE_ADDR = 32'hB000_0000,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [DATA_W-1:0] ERR_DATA  = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned LANE_BITS = $clog2(BYTES);
  localparam int unsigned IDX_W     = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic [DATA_W-1:0] mem [DEPTH];

  addr_t             off;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic              ready;
  logic              is_wr;
  logic              rd_req;
  logic              wr_ok;
  logic              wr_bad;
  logic              wr_err_q;
  logic [DATA_W-1:0] rd_dat;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdat;
  logic [BYTES-1:0]  mem_be;

  logic              pipe_err;

  assign off     = addr - BASE_ADDR;
  assign acc_idx = IDX_W'(off >> LANE_BITS);
  assign acc_err = addr_bad(addr, BASE_ADDR, LANE_BITS, addr_t'(DEPTH));

  assign ready  = (state_q == ST_READY);
  assign is_wr  = |we;
  assign rd_req = ready && en && !is_wr;
  assign wr_ok  = ready && en && is_wr && !acc_err;
  assign wr_bad = ready && en && is_wr && acc_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      wr_err_q <= wr_bad;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    busy    = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy    = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // The sweep owns the write port until it finishes; user writes only after.
  always_comb begin
    mem_we   = 1'b0;
    mem_idx  = acc_idx;
    mem_wdat = wdata;
    mem_be   = we;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        mem_we   = 1'b1;
        mem_idx  = sweep_q;
        mem_wdat = DATA_W'(sweep_q);
        mem_be   = '1;
      end else if (wr_ok) begin
        mem_we   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= mem_wdat[b*8 +: 8];
        end
      end
    end
  end

  // Array is sampled at the request edge, so a write one cycle earlier is visible.
  assign rd_dat = acc_err ? ERR_DATA : mem[acc_idx];

  bram_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rd_req),
    .in_err  (rd_req && acc_err),
    .in_dat  (rd_dat),
    .out_vld (rvalid),
    .out_err (pipe_err),
    .out_dat (rdata)
  );

  assign err = pipe_err || wr_err_q;

endmodule

// File: tb/tb_bram_model.sv
// Directed bench: two instances (RD_LAT=1 and RD_LAT=3) driven by shared inputs.
module tb_bram_model;

  localparam logic [31:0] BASE = 32'hB000_0000;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata1, rdata3;
  logic        rvalid1, rvalid3;
  logic        err1, err3;
  logic        busy1, busy3;

  int vectors;
  int miscompares;

  bram_model #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rvalid(rvalid1), .err(err1), .busy(busy1)
  );

  bram_model #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .rvalid(rvalid3), .err(err3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one request for one cycle, then land on the next falling edge.
  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  task automatic count_busy(output int c1, output int c3);
    int guard;
    c1 = 0;
    c3 = 0;
    guard = 0;
    while ((busy1 || busy3) && guard < 1000) begin
      if (busy1) c1++;
      if (busy3) c3++;
      guard++;
      @(negedge clk);
    end
  endtask

  initial begin
    int c1, c3;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    en    = 1'b0;
    we    = '0;
    addr  = '0;
    wdata = '0;

    repeat (3) @(negedge clk);
    check1 ("rst_rvalid1", rvalid1, 1'b0);
    check1 ("rst_err1",    err1,    1'b0);
    check1 ("rst_busy1",   busy1,   1'b1);
    check32("rst_rdata1",  rdata1,  32'hFFFF_FFFF);
    check1 ("rst_rvalid3", rvalid3, 1'b0);
    check32("rst_rdata3",  rdata3,  32'hFFFF_FFFF);

    reset = 1'b0;
    count_busy(c1, c3);
    check32("sweep_len1", 32'(c1), 32'd256);
    check32("sweep_len3", 32'(c3), 32'd256);

    // Single read of word 4 on both latencies, then hold of rdata.
    req(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    en = 1'b0;
    check1 ("rd10_rvalid1", rvalid1, 1'b1);
    check32("rd10_rdata1",  rdata1,  32'h0000_0004);
    check1 ("rd10_err1",    err1,    1'b0);
    @(negedge clk);
    check1 ("rd10_drop1",   rvalid1, 1'b0);
    check32("rd10_hold1",   rdata1,  32'h0000_0004);
    @(negedge clk);
    check1 ("rd10_rvalid3", rvalid3, 1'b1);
    check32("rd10_rdata3",  rdata3,  32'h0000_0004);
    repeat (3) req(1'b0, 4'h0, 32'h0, 32'h0);

    // Sixteen back-to-back reads; lat3 data appears after three edges.
    for (int t = 0; t < 21; t++) begin
      if (t < 16) req(1'b1, 4'h0, BASE + 32'(4 * t), 32'h0);
      else        req(1'b0, 4'h0, 32'h0, 32'h0);
      check1($sformatf("b2b_v3[%0d]", t), rvalid3, (t >= 2 && t < 18));
      if (t >= 2 && t < 18) check32($sformatf("b2b_d3[%0d]", t), rdata3, 32'(t - 2));
      check1($sformatf("b2b_v1[%0d]", t), rvalid1, (t < 16));
      if (t < 16) check32($sformatf("b2b_d1[%0d]", t), rdata1, 32'(t));
    end

    // Byte-lane write over word 0 (holding 0).
    req(1'b1, 4'b0101, BASE, 32'hDEAD_BEEF);
    check1("bl_wr_rvalid1", rvalid1, 1'b0);
    check1("bl_wr_err1",    err1,    1'b0);
    req(1'b1, 4'h0, BASE, 32'h0);
    check1 ("bl_rvalid1", rvalid1, 1'b1);
    check32("bl_rdata1",  rdata1,  32'h00AD_00EF);

    // Erroneous reads: misaligned, below window, past last word.
    req(1'b1, 4'h0, 32'hB000_0002, 32'h0);
    check1 ("emis_rvalid1", rvalid1, 1'b1);
    check1 ("emis_err1",    err1,    1'b1);
    check32("emis_rdata1",  rdata1,  32'hFFFF_FFFF);
    req(1'b1, 4'h0, 32'hAFFF_FFFC, 32'h0);
    check1 ("elow_rvalid1", rvalid1, 1'b1);
    check1 ("elow_err1",    err1,    1'b1);
    check32("elow_rdata1",  rdata1,  32'hFFFF_FFFF);
    req(1'b1, 4'h0, 32'hB000_0400, 32'h0);
    check1 ("ehigh_rvalid1", rvalid1, 1'b1);
    check1 ("ehigh_err1",    err1,    1'b1);
    check32("ehigh_rdata1",  rdata1,  32'hFFFF_FFFF);
    check1 ("emis_rvalid3",  rvalid3, 1'b1);
    check1 ("emis_err3",     err3,    1'b1);
    check32("emis_rdata3",   rdata3,  32'hFFFF_FFFF);

    // Erroneous write: err pulse only, memory untouched.
    req(1'b1, 4'hF, 32'hB000_0400, 32'hCAFE_F00D);
    check1("ewr_err1",    err1,    1'b1);
    check1("ewr_rvalid1", rvalid1, 1'b0);
    req(1'b0, 4'h0, 32'h0, 32'h0);
    check1("ewr_errdrop1", err1,   1'b0);
    req(1'b1, 4'h0, BASE, 32'h0);
    check32("ewr_word0",   rdata1, 32'h00AD_00EF);
    check1 ("ewr_rd_err1", err1,   1'b0);

    // Write at cycle n, read same address at n+1.
    req(1'b1, 4'hF, BASE + 32'h20, 32'h1234_5678);
    req(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    check1 ("wtr_rvalid1", rvalid1, 1'b1);
    check32("wtr_rdata1",  rdata1,  32'h1234_5678);
    repeat (4) req(1'b0, 4'h0, 32'h0, 32'h0);

    // Reset with two lat3 reads in flight.
    req(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    req(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    en    = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1($sformatf("mrst_rvalid3[%0d]", k), rvalid3, 1'b0);
      check1($sformatf("mrst_busy3[%0d]", k),   busy3,   1'b1);
    end
    check32("mrst_rdata3", rdata3, 32'hFFFF_FFFF);
    reset = 1'b0;
    count_busy(c1, c3);
    check32("resweep_len3", 32'(c3), 32'd256);
    check32("resweep_len1", 32'(c1), 32'd256);

    // Previously overwritten words are restored by the restarted sweep.
    req(1'b1, 4'h0, BASE, 32'h0);
    check32("resweep_w0",  rdata1, 32'h0000_0000);
    req(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    check32("resweep_w8",  rdata1, 32'h0000_0008);
    req(1'b0, 4'h0, 32'h0, 32'h0);
    check1 ("resweep_rvalid3", rvalid3, 1'b1);
    check32("resweep_w0_3",    rdata3,  32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule
